// File: rtl/mem_arbiter_512.sv
// mem_arbiter_512: two-port REQ/ACK arbiter and sequencer
// for a single-port 512x16 data memory.
//
// Ports:
//   i_clk, i_rst_n       clock, sync active-low reset
//   i_req_a, i_addr_a    fetch port request (read-only)
//   o_ack_a, o_rdata_a   fetch port ack pulse, read data
//   i_req_b, i_we_b,     load/store port request,
//   i_addr_b, i_wdata_b  write flag, address, write data
//   o_ack_b, o_rdata_b   load/store ack pulse, read data
//   o_ram_e/r/w          memory enable, read, write strobes
//   o_ram_addr, o_ram_d  memory address and write data
//   i_ram_out            memory read data
//   o_busy               high in ACCESS and RESP
module mem_arbiter_512 #(
  parameter int WAIT_STATES = 0,
  parameter int ROUND_ROBIN = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_a,
  input  logic [8:0]  i_addr_a,
  output logic        o_ack_a,
  output logic [15:0] o_rdata_a,
  input  logic        i_req_b,
  input  logic        i_we_b,
  input  logic [8:0]  i_addr_b,
  input  logic [15:0] i_wdata_b,
  output logic        o_ack_b,
  output logic [15:0] o_rdata_b,
  output logic        o_ram_e,
  output logic        o_ram_r,
  output logic        o_ram_w,
  output logic [8:0]  o_ram_addr,
  output logic [15:0] o_ram_d,
  input  logic [15:0] i_ram_out,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_last_b;
  logic        r_sel_b;
  logic [8:0]  r_addr;
  logic [15:0] r_wdata;
  logic        r_ack_a;
  logic        r_ack_b;
  logic        r_busy;
  logic        r_ram_e;
  logic        r_ram_r;
  logic        r_ram_w;
  logic [15:0] r_rdata_a;
  logic [15:0] r_rdata_b;

  logic w_rr;
  logic w_req_any;
  logic w_pick_b;
  logic w_wr;

  assign w_rr      = (ROUND_ROBIN != 0);
  assign w_req_any = i_req_a | i_req_b;
  // B wins when alone, under fixed priority,
  // or when A was the last port granted.
  assign w_pick_b  = i_req_b &
                     (~i_req_a | ~w_rr | ~r_last_b);
  assign w_wr      = w_pick_b & i_we_b;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 3'd0;
      r_last_b  <= 1'b1;
      r_sel_b   <= 1'b0;
      r_addr    <= 9'd0;
      r_wdata   <= 16'd0;
      r_ack_a   <= 1'b0;
      r_ack_b   <= 1'b0;
      r_busy    <= 1'b0;
      r_ram_e   <= 1'b0;
      r_ram_r   <= 1'b0;
      r_ram_w   <= 1'b0;
      r_rdata_a <= 16'd0;
      r_rdata_b <= 16'd0;
    end else begin
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_state  <= S_ACCESS;
            r_cnt    <= 3'(WAIT_STATES);
            r_last_b <= w_pick_b;
            r_sel_b  <= w_pick_b;
            r_addr   <= w_pick_b ? i_addr_b
                                 : i_addr_a;
            if (w_pick_b) r_wdata <= i_wdata_b;
            r_busy   <= 1'b1;
            r_ram_e  <= 1'b1;
            r_ram_r  <= ~w_wr;
            r_ram_w  <= w_wr;
          end
        end
        S_ACCESS: begin
          if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
          end else begin
            r_state <= S_RESP;
            r_ram_e <= 1'b0;
            r_ram_r <= 1'b0;
            r_ram_w <= 1'b0;
            // Strobe flags are still valid on
            // this edge; capture before clearing.
            if (r_sel_b) begin
              r_ack_b <= 1'b1;
              if (!r_ram_w) r_rdata_b <= i_ram_out;
            end else begin
              r_ack_a   <= 1'b1;
              r_rdata_a <= i_ram_out;
            end
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ack_a    = r_ack_a;
  assign o_ack_b    = r_ack_b;
  assign o_rdata_a  = r_rdata_a;
  assign o_rdata_b  = r_rdata_b;
  assign o_ram_e    = r_ram_e;
  assign o_ram_r    = r_ram_r;
  assign o_ram_w    = r_ram_w;
  assign o_ram_addr = r_addr;
  assign o_ram_d    = r_wdata;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_mem_arbiter_512.sv
// tb_mem_arbiter_512: directed bench for mem_arbiter_512
// across three parameter builds with a memory model each.
module tb_mem_arbiter_512;

  logic        clk;
  logic        rst_n;
  logic        pre_we;
  logic [8:0]  pre_addr;
  logic [15:0] pre_data;

  logic        req_a    [3];
  logic [8:0]  addr_a   [3];
  logic        ack_a    [3];
  logic [15:0] rdata_a  [3];
  logic        req_b    [3];
  logic        we_b     [3];
  logic [8:0]  addr_b   [3];
  logic [15:0] wdata_b  [3];
  logic        ack_b    [3];
  logic [15:0] rdata_b  [3];
  logic        ram_e    [3];
  logic        ram_r    [3];
  logic        ram_w    [3];
  logic [8:0]  ram_addr [3];
  logic [15:0] ram_d    [3];
  logic [15:0] ram_out  [3];
  logic        busy     [3];

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // gen[0]: WS=0 RR=1, gen[1]: WS=0 RR=0,
  // gen[2]: WS=3 RR=1
  for (genvar g = 0; g < 3; g++) begin : gen
    logic [15:0] mem [512];
    mem_arbiter_512 #(
      .WAIT_STATES(g == 2 ? 3 : 0),
      .ROUND_ROBIN(g == 1 ? 0 : 1)
    ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_req_a    (req_a[g]),
      .i_addr_a   (addr_a[g]),
      .o_ack_a    (ack_a[g]),
      .o_rdata_a  (rdata_a[g]),
      .i_req_b    (req_b[g]),
      .i_we_b     (we_b[g]),
      .i_addr_b   (addr_b[g]),
      .i_wdata_b  (wdata_b[g]),
      .o_ack_b    (ack_b[g]),
      .o_rdata_b  (rdata_b[g]),
      .o_ram_e    (ram_e[g]),
      .o_ram_r    (ram_r[g]),
      .o_ram_w    (ram_w[g]),
      .o_ram_addr (ram_addr[g]),
      .o_ram_d    (ram_d[g]),
      .i_ram_out  (ram_out[g]),
      .o_busy     (busy[g])
    );
    always @(posedge clk) begin
      if (pre_we)
        mem[pre_addr] <= pre_data;
      else if (ram_e[g] && ram_w[g])
        mem[ram_addr[g]] <= ram_d[g];
    end
    assign ram_out[g] = ram_r[g] ?
      mem[ram_addr[g]] : 16'hDEAD;
  end

  typedef struct {
    logic        ra;
    logic [8:0]  aa;
    logic        rb;
    logic        wb;
    logic [8:0]  ab;
    logic [15:0] wd;
    logic        xa;
    logic        xb;
    logic        xbusy;
    logic        xe;
    logic        xr;
    logic        xw;
    logic [8:0]  xaddr;
    logic [15:0] xrda;
    logic [15:0] xrdb;
  } vec_t;

  vec_t tbl [16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h",
               nm, act, exp);
    end
  endtask

  localparam logic [8:0] AA = 9'h010;
  localparam logic [8:0] AB = 9'h020;
  localparam logic [8:0] AT = 9'h1FF;
  localparam logic [8:0] AW = 9'h040;

  initial begin
    checks = 0;
    errors = 0;

    // B=0, A=1 pattern fields:
    // ra aa rb wb ab wd | xa xb busy e r w addr rda rdb
    tbl[0]  = '{1'b1, AA, 1'b1, 1'b0, AB, 16'h0,
      1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, AA,
      16'h0000, 16'h0000};
    tbl[1]  = '{1'b1, AA, 1'b1, 1'b0, AB, 16'h0,
      1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, AA,
      16'hA010, 16'h0000};
    tbl[2]  = '{1'b1, AA, 1'b1, 1'b0, AB, 16'h0,
      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, AA,
      16'hA010, 16'h0000};
    tbl[3]  = '{1'b1, AA, 1'b1, 1'b0, AB, 16'h0,
      1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, AB,
      16'hA010, 16'h0000};
    tbl[4]  = '{1'b1, AA, 1'b1, 1'b0, AB, 16'h0,
      1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, AB,
      16'hA010, 16'hB020};
    tbl[5]  = '{1'b1, AA, 1'b1, 1'b0, AB, 16'h0,
      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, AB,
      16'hA010, 16'hB020};
    tbl[6]  = '{1'b1, AA, 1'b1, 1'b0, AB, 16'h0,
      1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, AA,
      16'hA010, 16'hB020};
    tbl[7]  = '{1'b1, AA, 1'b1, 1'b0, AB, 16'h0,
      1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, AA,
      16'hA010, 16'hB020};
    tbl[8]  = '{1'b0, AA, 1'b0, 1'b0, AB, 16'h0,
      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, AA,
      16'hA010, 16'hB020};
    tbl[9]  = '{1'b0, AA, 1'b1, 1'b1, AT, 16'hBEEF,
      1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, AT,
      16'hA010, 16'hB020};
    tbl[10] = '{1'b0, AA, 1'b1, 1'b1, AT, 16'hBEEF,
      1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, AT,
      16'hA010, 16'hB020};
    tbl[11] = '{1'b0, AA, 1'b0, 1'b1, AT, 16'hBEEF,
      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, AT,
      16'hA010, 16'hB020};
    tbl[12] = '{1'b1, AT, 1'b0, 1'b0, AT, 16'h0,
      1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, AT,
      16'hA010, 16'hB020};
    tbl[13] = '{1'b1, AT, 1'b0, 1'b0, AT, 16'h0,
      1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, AT,
      16'hBEEF, 16'hB020};
    tbl[14] = '{1'b0, AT, 1'b0, 1'b0, AT, 16'h0,
      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, AT,
      16'hBEEF, 16'hB020};
    tbl[15] = '{1'b0, AT, 1'b0, 1'b0, AT, 16'h0,
      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, AT,
      16'hBEEF, 16'hB020};

    rst_n    = 1'b0;
    pre_we   = 1'b0;
    pre_addr = 9'd0;
    pre_data = 16'd0;
    for (int g = 0; g < 3; g++) begin
      req_a[g]   = 1'b0;
      addr_a[g]  = AA;
      req_b[g]   = 1'b0;
      we_b[g]    = 1'b0;
      addr_b[g]  = AB;
      wdata_b[g] = 16'h0;
    end

    // preload every model memory
    step();
    pre_we = 1'b1;
    pre_addr = AA; pre_data = 16'hA010;
    step();
    pre_addr = AB; pre_data = 16'hB020;
    step();
    pre_addr = AW; pre_data = 16'h1234;
    step();
    pre_we = 1'b0;

    // reset with both requests held
    for (int g = 0; g < 3; g++) begin
      req_a[g] = 1'b1;
      req_b[g] = 1'b1;
    end
    step();
    step();
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst%0d ack_a", g),
          16'(ack_a[g]), 16'h0);
      chk($sformatf("rst%0d ack_b", g),
          16'(ack_b[g]), 16'h0);
      chk($sformatf("rst%0d busy", g),
          16'(busy[g]), 16'h0);
      chk($sformatf("rst%0d ram_e", g),
          16'(ram_e[g]), 16'h0);
      chk($sformatf("rst%0d ram_r", g),
          16'(ram_r[g]), 16'h0);
      chk($sformatf("rst%0d ram_w", g),
          16'(ram_w[g]), 16'h0);
      chk($sformatf("rst%0d ram_addr", g),
          16'(ram_addr[g]), 16'h0);
      chk($sformatf("rst%0d ram_d", g),
          ram_d[g], 16'h0);
      chk($sformatf("rst%0d rdata_a", g),
          rdata_a[g], 16'h0);
      chk($sformatf("rst%0d rdata_b", g),
          rdata_b[g], 16'h0);
    end
    rst_n = 1'b1;
    for (int g = 1; g < 3; g++) begin
      req_a[g] = 1'b0;
      req_b[g] = 1'b0;
    end

    // WS=0 RR=1: contention, write, read back
    for (int i = 0; i < 16; i++) begin
      req_a[0]   = tbl[i].ra;
      addr_a[0]  = tbl[i].aa;
      req_b[0]   = tbl[i].rb;
      we_b[0]    = tbl[i].wb;
      addr_b[0]  = tbl[i].ab;
      wdata_b[0] = tbl[i].wd;
      step();
      chk($sformatf("v%0d ack_a", i),
          16'(ack_a[0]), 16'(tbl[i].xa));
      chk($sformatf("v%0d ack_b", i),
          16'(ack_b[0]), 16'(tbl[i].xb));
      chk($sformatf("v%0d busy", i),
          16'(busy[0]), 16'(tbl[i].xbusy));
      chk($sformatf("v%0d ram_e", i),
          16'(ram_e[0]), 16'(tbl[i].xe));
      chk($sformatf("v%0d ram_r", i),
          16'(ram_r[0]), 16'(tbl[i].xr));
      chk($sformatf("v%0d ram_w", i),
          16'(ram_w[0]), 16'(tbl[i].xw));
      chk($sformatf("v%0d ram_addr", i),
          16'(ram_addr[0]), 16'(tbl[i].xaddr));
      chk($sformatf("v%0d rdata_a", i),
          rdata_a[0], tbl[i].xrda);
      chk($sformatf("v%0d rdata_b", i),
          rdata_b[0], tbl[i].xrdb);
    end
    chk("mem0 1FF", gen[0].mem[AT], 16'hBEEF);

    // WS=0 RR=0: B starves A while it requests
    req_a[1]  = 1'b1;
    addr_a[1] = AA;
    req_b[1]  = 1'b1;
    we_b[1]   = 1'b0;
    addr_b[1] = AB;
    for (int c = 0; c < 9; c++) begin
      step();
      chk($sformatf("fp%0d ack_b", c),
          16'(ack_b[1]), 16'(c % 3 == 1));
      chk($sformatf("fp%0d ack_a", c),
          16'(ack_a[1]), 16'h0);
    end
    chk("fp rdata_b", rdata_b[1], 16'hB020);
    req_b[1] = 1'b0;
    step();
    chk("fp a busy", 16'(busy[1]), 16'h1);
    chk("fp a early", 16'(ack_a[1]), 16'h0);
    step();
    chk("fp a ack", 16'(ack_a[1]), 16'h1);
    chk("fp a ack_b", 16'(ack_b[1]), 16'h0);
    chk("fp a rdata", rdata_a[1], 16'hA010);
    req_a[1] = 1'b0;
    step();
    chk("fp a end", 16'(ack_a[1]), 16'h0);
    chk("fp a idle", 16'(busy[1]), 16'h0);

    // WS=3: B read of 0x040
    req_b[2]  = 1'b1;
    we_b[2]   = 1'b0;
    addr_b[2] = AW;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("ws%0d ram_r", c),
          16'(ram_r[2]), 16'h1);
      chk($sformatf("ws%0d ack_b", c),
          16'(ack_b[2]), 16'h0);
      chk($sformatf("ws%0d busy", c),
          16'(busy[2]), 16'h1);
    end
    step();
    chk("ws ack_b", 16'(ack_b[2]), 16'h1);
    chk("ws ram_r", 16'(ram_r[2]), 16'h0);
    chk("ws rdata_b", rdata_b[2], 16'h1234);
    chk("ws rdata_a", rdata_a[2], 16'h0);
    req_b[2] = 1'b0;
    step();
    chk("ws ack end", 16'(ack_b[2]), 16'h0);
    chk("ws busy end", 16'(busy[2]), 16'h0);

    // WS=3: reset in second ACCESS cycle
    req_b[2] = 1'b1;
    step();
    chk("mr acc1", 16'(ram_r[2]), 16'h1);
    step();
    chk("mr acc2", 16'(busy[2]), 16'h1);
    rst_n    = 1'b0;
    req_b[2] = 1'b0;
    step();
    chk("mr ack_b", 16'(ack_b[2]), 16'h0);
    chk("mr busy", 16'(busy[2]), 16'h0);
    chk("mr ram_e", 16'(ram_e[2]), 16'h0);
    chk("mr ram_r", 16'(ram_r[2]), 16'h0);
    chk("mr ram_w", 16'(ram_w[2]), 16'h0);
    chk("mr rdata_b", rdata_b[2], 16'h0);
    rst_n = 1'b1;
    step();
    chk("mr post ack", 16'(ack_b[2]), 16'h0);
    chk("mr post busy", 16'(busy[2]), 16'h0);
    req_b[2] = 1'b1;
    begin
      int n;
      bit found;
      n = 0;
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
        step();
        n++;
        if (ack_b[2]) found = 1'b1;
      end
      chk("mr reissue latency", 16'(n), 16'd5);
      chk("mr reissue rdata", rdata_b[2],
          16'h1234);
    end
    req_b[2] = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_512.md
# mem_arbiter_512

Two-port arbiter and sequencer for the single-port 512×16 data memory. It shares the memory between the instruction-fetch port (A, read-only) and the load/store port (B, read/write). Each transfer uses a REQ/ACK handshake. The block latches the winning request, drives the memory's enable, read, write, address and data pins for a fixed number of cycles, captures read data into a per-port register and returns a one-cycle ACK.

## Interface
- WAIT_STATES, default 0: extra ACCESS cycles per transfer (0–7) for slow memory builds.
- ROUND_ROBIN, default 1: 1 = alternate priority on contention; 0 = port B always wins.
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- REQ_A  in  1  port A request; held with ADDR_A until ACK_A.
- ADDR_A  in  9  port A word address.
- ACK_A  out  1  one-cycle completion pulse for port A.
- RDATA_A  out  16  port A read data, registered.
- REQ_B  in  1  port B request; held with ADDR_B, WE_B and WDATA_B until ACK_B.
- WE_B  in  1  1 = write, 0 = read.
- ADDR_B  in  9  port B word address.
- WDATA_B  in  16  port B write data.
- ACK_B  out  1  one-cycle completion pulse for port B.
- RDATA_B  out  16  port B read data, registered.
- RAM_E  out  1  memory enable.
- RAM_R  out  1  memory read strobe.
- RAM_W  out  1  memory write strobe.
- RAM_ADDR  out  9  memory address.
- RAM_D  out  16  memory write data.
- RAM_OUT  in  16  memory read data; undefined whenever RAM_R=0.
- BUSY  out  1  high in ACCESS and RESP.

## Operation

**States**
- IDLE, ACCESS and RESP. State is 2 bits.
- A wait counter (3 bits) and a LAST_GNT bit track progress and fairness.

**IDLE**
- Samples REQ_A and REQ_B at each edge.
- If neither is asserted, the block stays in IDLE.
- If exactly one is asserted, that port wins.
- If both are asserted and ROUND_ROBIN=1, the port not recorded in LAST_GNT wins. If ROUND_ROBIN=0, B wins.
- On a win, the block latches the winner's address, write flag (always 0 for A) and write data into internal registers.
- It then loads the wait counter with WAIT_STATES, updates LAST_GNT to the winner, and goes to ACCESS.

**ACCESS**
- Drives RAM_E=1 and RAM_ADDR/RAM_D from the latched registers.
- Drives RAM_W=latched write flag and RAM_R=NOT latched write flag.
- If the counter is non-zero, it decrements and the block stays in ACCESS.
- If the counter is zero, the block goes to RESP.
- On that transition edge, a read loads RAM_OUT into the winner's RDATA register, and the winner's ACK register is set.
- The other port's RDATA is untouched.

**RESP**
- The winner's ACK is high for exactly this cycle.
- REQ inputs are ignored in this state.
- The block always returns to IDLE.
- The requester drops REQ, or presents a new request, during the ACK cycle.

**Memory pins outside ACCESS**
- RAM_E=0, RAM_R=0, RAM_W=0.
- RAM_ADDR and RAM_D hold their latched values.

**Write handling**
- A write keeps RAM_W high for all 1+WAIT_STATES ACCESS cycles.
- The memory stores the same word on each of those edges; this is acceptable.
- RDATA_B is unchanged by writes.

**Reset (RST_N=0 at an edge)**
- State goes to IDLE and the counter to 0.
- LAST_GNT goes to B, so A wins the first contention.
- ACK_A, ACK_B and BUSY go to 0.
- RDATA_A, RDATA_B, RAM_ADDR and RAM_D go to 0.
- RAM_E, RAM_R and RAM_W go to 0.
- A transfer in flight is abandoned with no ACK. A write may or may not have landed.
- Requesters must re-issue after reset.

## Timing
- A request is sampled at edge T0 in IDLE. ACCESS occupies cycles T0+1 through T0+1+WAIT_STATES. ACK is high in the following cycle.
- With WAIT_STATES=0: ACK is high in the second cycle after the sampling edge. Throughput is one transfer per 3 cycles.
- Read data is valid in RDATA_x in the same cycle as ACK_x. It stays stable until that port's next read completes.
- ACK_A and ACK_B are never high together. BUSY=1 exactly from the first ACCESS cycle through RESP.
- A request arriving while BUSY is held and served no earlier than the next IDLE.
- The losing port is served at the next IDLE: with ROUND_ROBIN=1 it cannot lose twice in a row.
- Address wraps naturally: 9'h1FF is valid and there is no out-of-range case.
- A request asserted at the same edge RST_N is low is discarded.
- All outputs are registered or decoded from state and registers only. There is no combinational path from REQ to any RAM_* pin.

## Test plan
- **Reset:** hold RST_N=0 two cycles with REQ_A=REQ_B=1 -> all outputs 0 and state IDLE; after release, A is granted first.
- **B write then A read, WAIT_STATES=0:**
  - B writes ADDR=9'h1FF, WDATA=16'hBEEF -> ACK_B 2 cycles after sampling and RAM_W high for exactly 1 cycle.
  - A then reads 9'h1FF -> RDATA_A=16'hBEEF with ACK_A.
- **Contention, ROUND_ROBIN=1:** hold REQ_A and REQ_B continuously -> ACKs alternate A,B,A,B, one every 3 cycles; never simultaneous.
- **Fixed priority, ROUND_ROBIN=0:** hold both requests -> B served every transfer while B stays requesting; A served only after B drops REQ_B.
- **Wait states, WAIT_STATES=3:**
  - B reads 9'h040 preloaded with 16'h1234 -> RAM_R high 4 cycles, ACK_B in the 5th cycle after sampling, RDATA_B=16'h1234.
  - RDATA_A unchanged.
- **Reset mid-transfer:** drop RST_N during the second ACCESS cycle of a WAIT_STATES=3 read -> no ACK, BUSY=0 and RAM_* strobes 0 next cycle; a re-issued request completes normally.
